// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 32-bit word per cycle through four arithmetic S-boxes.
// Optional macro INV_SBOX_EN adds the inv port and the inverse S-box path.
module sub_bytes_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef INV_SBOX_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] sbox_to_rows,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_r, state_s;
  logic [1:0]   cnt_r, cnt_s;
  logic [127:0] work_r, work_s;
  logic         in_ready_r, in_ready_s;
  logic         out_valid_r, out_valid_s;
  logic         busy_r, busy_s;
  logic         inv_sel_s;
  logic [31:0]  word_s;
  logic [31:0]  sub_word_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and 0 naturally maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv_sel);
    if (inv_sel) return gf_inv(affine_inv(b));
    else         return affine_fwd(gf_inv(b));
  endfunction

`ifdef INV_SBOX_EN
  logic inv_r, inv_s;

  // Direction captured at accept so mid-block toggles of inv are ignored.
  always_comb begin
    inv_s = inv_r;
    if ((state_r == ST_IDLE) && in_valid) inv_s = inv;
    else                                  inv_s = inv_r;
  end

  // Direction register.
  always_ff @(posedge clk) begin
    if (rst) inv_r <= 1'b0;
    else     inv_r <= inv_s;
  end

  assign inv_sel_s = inv_r;
`else
  assign inv_sel_s = 1'b0;
`endif

  // Word selected by the counter, most significant word first.
  always_comb begin
    word_s = 32'h0000_0000;
    case (cnt_r)
      2'd0:    word_s = work_r[127:96];
      2'd1:    word_s = work_r[95:64];
      2'd2:    word_s = work_r[63:32];
      2'd3:    word_s = work_r[31:0];
      default: word_s = 32'h0000_0000;
    endcase
  end

  // Four S-box instances working on the selected word.
  always_comb begin
    sub_word_s = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      sub_word_s[8*i +: 8] = sbox(word_s[8*i +: 8], inv_sel_s);
    end
  end

  // Next-state, counter and working-register update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    work_s  = work_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_BUSY;
          cnt_s   = 2'd0;
          work_s  = state_in;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        case (cnt_r)
          2'd0:    work_s[127:96] = sub_word_s;
          2'd1:    work_s[95:64]  = sub_word_s;
          2'd2:    work_s[63:32]  = sub_word_s;
          2'd3:    work_s[31:0]   = sub_word_s;
          default: work_s         = work_r;
        endcase
        cnt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) state_s = ST_DONE;
        else               state_s = ST_BUSY;
      end
      ST_DONE: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // Status flags are computed from the next state so they come straight from flops.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_s)
      ST_IDLE: in_ready_s  = 1'b1;
      ST_BUSY: busy_s      = 1'b1;
      ST_DONE: out_valid_s = 1'b1;
      default: in_ready_s  = 1'b0;
    endcase
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      work_r      <= 128'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      work_r      <= work_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign busy         = busy_r;
  assign sbox_to_rows = work_r;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Randomized self-checking bench for sub_bytes_iter against a table-based S-box model.
module tb_sub_bytes_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] sbox_to_rows;
  logic         busy;

  int vectors;
  int miscompares;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  sub_bytes_iter dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .state_in     (state_in),
`ifdef INV_SBOX_EN
    .inv          (inv),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sbox_to_rows (sbox_to_rows),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rot8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box tables via the generator-3 walk over GF(2^8)*; inverse table by inversion.
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      fwd_tab[p] = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = i[7:0];
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv_sel);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv_sel ? inv_tab[s[8*i +: 8]] : fwd_tab[s[8*i +: 8]];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block: accept, count latency, optional backpressure with ignored in_valid, handshake.
  task automatic run_block(input logic [127:0] data, input logic inv_sel,
                           input bit early_ready, input int hold,
                           input logic [127:0] exp);
    int n;
    logic [127:0] held;
    check("idle_in_ready", {127'd0, in_ready}, 128'd1);
    state_in  = data;
    inv       = inv_sel;
    in_valid  = 1'b1;
    out_ready = early_ready;
    tick();
    in_valid = 1'b0;
    state_in = ~data;
    n = 0;
    while (n < 20) begin
      if (out_valid === 1'b1) break;
      check("busy_flag", {126'd0, busy, in_ready}, 128'd2);
`ifdef INV_SBOX_EN
      inv = ~inv;
`endif
      tick();
      n++;
    end
    check("latency", 128'(n), 128'd4);
    check("result", sbox_to_rows, exp);
    held = sbox_to_rows;
    if (!early_ready) begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        state_in = {4{$urandom}};
        tick();
        check("hold_stable", sbox_to_rows, held);
        check("hold_flags", {126'd0, out_valid, in_ready}, 128'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    check("handshake_flags", {125'd0, out_valid, in_ready, busy}, 128'd2);
  endtask

  initial begin
    logic [127:0] d;
    logic         iv;
    logic [127:0] known_in;
    logic [127:0] known_out;
    vectors     = 0;
    miscompares = 0;
    build_tables();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = 128'd0;
    inv       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
    check("reset_data", sbox_to_rows, 128'd0);

    known_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    known_out = 128'hd42711aee0bf98f1b8b45de51e415230;
    run_block(known_in, 1'b0, 1'b1, 0, known_out);
    run_block(128'd0, 1'b0, 1'b1, 0, {16{8'h63}});
    run_block({16{8'h53}}, 1'b0, 1'b0, 1, {16{8'hed}});
    run_block(known_in, 1'b0, 1'b0, 10, known_out);

    // Reset during the count-2 cycle drops the block.
    state_in = known_in;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
    check("midreset_data", sbox_to_rows, 128'd0);
    run_block(known_in, 1'b0, 1'b0, 2, known_out);

    // Reset wins over a simultaneous output handshake.
    state_in = known_in;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_priority", sbox_to_rows, 128'd0);

`ifdef INV_SBOX_EN
    run_block(known_out, 1'b1, 1'b1, 0, known_in);
`endif

    for (int t = 0; t < 24; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_SBOX_EN
      iv = 1'($urandom_range(0, 1));
`else
      iv = 1'b0;
`endif
      run_block(d, iv, 1'($urandom_range(0, 1)), $urandom_range(0, 3), model(d, iv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
